// File: rtl/ahb_lite_arbiter.sv
// ahb_lite_arbiter: two-manager AHB-Lite arbiter with per-manager pending slots and round-robin issue
module ahb_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic              s_hresp
);
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DATA} state_e;
    state_e            st_q [2];
    state_e            st_d [2];
    logic [ADDR_W-1:0] addr_q [2];
    logic [ADDR_W-1:0] addr_d [2];
    logic              wr_q [2];
    logic              wr_d [2];
    logic [2:0]        sz_q [2];
    logic [2:0]        sz_d [2];
    logic              rr_q, rr_d;
    logic              lock_q, lock_d;
    logic              lock_sel_q, lock_sel_d;
    logic [ADDR_W-1:0] m_haddr [2];
    logic [1:0]        m_htrans [2];
    logic              m_hwrite [2];
    logic [2:0]        m_hsize [2];
    logic              pend [2];
    logic              rdy [2];
    logic              req [2];
    logic              any_pend;
    logic              sel;

    assign m_haddr[0]  = m0_haddr;
    assign m_haddr[1]  = m1_haddr;
    assign m_htrans[0] = m0_htrans;
    assign m_htrans[1] = m1_htrans;
    assign m_hwrite[0] = m0_hwrite;
    assign m_hwrite[1] = m1_hwrite;
    assign m_hsize[0]  = m0_hsize;
    assign m_hsize[1]  = m1_hsize;

    // Decode per-manager status and pick the slot driven downstream (locked choice wins while stalled)
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pend[i] = st_q[i] == ST_PEND;
            rdy[i]  = (st_q[i] == ST_IDLE) | ((st_q[i] == ST_DATA) & s_hready);
            req[i]  = m_htrans[i] inside {2'd2, 2'd3};
        end
        any_pend = pend[0] | pend[1];
        sel      = lock_q ? lock_sel_q : (pend[0] & pend[1]) ? rr_q : pend[1];
    end

    // Next state: capture whenever the manager sees ready, issue the selected slot on s_hready
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]   = rdy[i] ? (req[i] ? ST_PEND : ST_IDLE)
                      : (pend[i] & s_hready & (sel == 1'(i))) ? ST_DATA : st_q[i];
            addr_d[i] = (rdy[i] & req[i]) ? m_haddr[i] : addr_q[i];
            wr_d[i]   = (rdy[i] & req[i]) ? m_hwrite[i] : wr_q[i];
            sz_d[i]   = (rdy[i] & req[i]) ? m_hsize[i] : sz_q[i];
        end
        rr_d       = (any_pend & s_hready) ? ~sel : rr_q;
        lock_d     = any_pend & ~s_hready;
        lock_sel_d = sel;
    end

    // State, slot, round-robin and lock registers; reset drops everything in flight
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= ST_IDLE;
                addr_q[i] <= '0;
                wr_q[i]   <= 1'b0;
                sz_q[i]   <= '0;
            end
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= st_d[i];
                addr_q[i] <= addr_d[i];
                wr_q[i]   <= wr_d[i];
                sz_q[i]   <= sz_d[i];
            end
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    assign s_htrans  = any_pend ? 2'd2 : 2'd0;
    assign s_haddr   = any_pend ? addr_q[sel] : '0;
    assign s_hwrite  = any_pend & wr_q[sel];
    assign s_hsize   = any_pend ? sz_q[sel] : '0;
    assign s_hwdata  = (st_q[0] == ST_DATA) ? m0_hwdata : (st_q[1] == ST_DATA) ? m1_hwdata : '0;
    assign m0_hready = rdy[0];
    assign m1_hready = rdy[1];
    assign m0_hresp  = (st_q[0] == ST_DATA) & s_hresp;
    assign m1_hresp  = (st_q[1] == ST_DATA) & s_hresp;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// tb_ahb_lite_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_ahb_lite_arbiter;
    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] m_haddr [2];
    logic [1:0]  m_htrans [2];
    logic        m_hwrite [2];
    logic [2:0]  m_hsize [2];
    logic [31:0] m_hwdata [2];
    logic [31:0] m_hrdata [2];
    logic        m_hready [2];
    logic        m_hresp [2];
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [1:0]  s_htrans;
    logic        s_hwrite, s_hready, s_hresp;
    logic [2:0]  s_hsize;
    int          n_checks = 0;
    int          n_fail = 0;

    ahb_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .m0_haddr(m_haddr[0]), .m0_htrans(m_htrans[0]), .m0_hwrite(m_hwrite[0]), .m0_hsize(m_hsize[0]),
        .m0_hwdata(m_hwdata[0]), .m0_hrdata(m_hrdata[0]), .m0_hready(m_hready[0]), .m0_hresp(m_hresp[0]),
        .m1_haddr(m_haddr[1]), .m1_htrans(m_htrans[1]), .m1_hwrite(m_hwrite[1]), .m1_hsize(m_hsize[1]),
        .m1_hwdata(m_hwdata[1]), .m1_hrdata(m_hrdata[1]), .m1_hready(m_hready[1]), .m1_hresp(m_hresp[1]),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
    );

    always #5 clk = ~clk;

    // Reference model: which managers hold a waiting request, who owns the data phase, whose turn it is
    bit          r_pend [2];
    int          r_owner;
    int          r_pref;
    int          r_lock;
    logic [31:0] r_addr [2];
    logic        r_wr [2];
    logic [2:0]  r_sz [2];

    function automatic int r_grant();
        if (r_lock >= 0) return r_lock;
        if (r_pend[0] && r_pend[1]) return r_pref;
        return r_pend[1] ? 1 : 0;
    endfunction

    function automatic bit r_ready(int m);
        return (!r_pend[m] && r_owner != m) || (r_owner == m && s_hready);
    endfunction

    task automatic model_reset();
        r_pend[0] = 0; r_pend[1] = 0; r_owner = -1; r_pref = 0; r_lock = -1;
    endtask

    task automatic model_edge();
        int g = r_grant();
        bit any = r_pend[0] | r_pend[1];
        bit rd [2];
        for (int m = 0; m < 2; m++) rd[m] = r_ready(m);
        if (s_hready) begin
            if (any) begin
                r_pend[g] = 0;
                r_pref = 1 - g;
            end
            r_owner = any ? g : -1;
            r_lock = -1;
        end else if (any) begin
            r_lock = g;
        end
        for (int m = 0; m < 2; m++)
            if (rd[m] && m_htrans[m] >= 2'd2) begin
                r_pend[m] = 1;
                r_addr[m] = m_haddr[m];
                r_wr[m] = m_hwrite[m];
                r_sz[m] = m_hsize[m];
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int m = 0; m < 2; m++) begin
            m_haddr[m] = '0; m_htrans[m] = 2'd0; m_hwrite[m] = 1'b0; m_hsize[m] = '0; m_hwdata[m] = '0;
        end
        s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;
    endtask

    task automatic set_req(int m, logic [1:0] t, logic [31:0] a, logic w, logic [2:0] sz);
        m_htrans[m] = t; m_haddr[m] = a; m_hwrite[m] = w; m_hsize[m] = sz;
    endtask

    task automatic do_reset();
        idle_inputs();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({s_htrans, s_haddr, s_hwrite, s_hsize, s_hwdata} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_downstream: got htrans=%0d haddr=%h hwdata=%h, want all zero", s_htrans, s_haddr, s_hwdata);
        end
        n_checks++;
        if ({m_hready[0], m_hready[1], m_hresp[0], m_hresp[1]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_managers: got rdy=%b%b resp=%b%b, want rdy=11 resp=00", m_hready[0], m_hready[1], m_hresp[0], m_hresp[1]);
        end
        tick();
    endtask

    task automatic test_lone_write();
        set_req(0, 2'd2, 32'h4000_0004, 1'b1, 3'd2);
        tick();
        m_htrans[0] = 2'd0;
        m_hwdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({s_htrans, s_haddr, s_hwrite, s_hsize} !== {2'd2, 32'h4000_0004, 1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL lone_addr_phase: got htrans=%0d haddr=%h w=%b sz=%0d, want 2 40000004 1 2", s_htrans, s_haddr, s_hwrite, s_hsize);
        end
        n_checks++;
        if (m_hready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_hready_t1: got %b want 0", m_hready[0]);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (s_hwdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL lone_hwdata: got %h want deadbeef", s_hwdata);
        end
        n_checks++;
        if ({m_hready[0], s_htrans} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL lone_t2: got hready=%b htrans=%0d want 1 0", m_hready[0], s_htrans);
        end
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        set_req(0, 2'd2, 32'h4000_0100, 1'b0, 3'd2);
        set_req(1, 2'd2, 32'h4000_0200, 1'b1, 3'd2);
        tick();
        m_htrans[0] = 2'd0; m_htrans[1] = 2'd0;
        @(negedge clk);
        n_checks++;
        if ({s_htrans, s_haddr} !== {2'd2, 32'h4000_0100}) begin
            n_fail++;
            $display("FAIL collide1_first: got htrans=%0d haddr=%h want m0 40000100", s_htrans, s_haddr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({s_htrans, s_haddr, s_hwrite, m_hready[0]} !== {2'd2, 32'h4000_0200, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL collide1_second: got htrans=%0d haddr=%h w=%b m0rdy=%b want m1 40000200 w=1 rdy=1", s_htrans, s_haddr, s_hwrite, m_hready[0]);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({s_htrans, m_hready[1]} !== {2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL collide1_drain: got htrans=%0d m1rdy=%b want 0 1", s_htrans, m_hready[1]);
        end
        tick();
        set_req(0, 2'd2, 32'h4000_0300, 1'b0, 3'd2);
        tick();
        m_htrans[0] = 2'd0;
        repeat (2) tick();
        set_req(0, 2'd2, 32'h4000_0400, 1'b0, 3'd2);
        set_req(1, 2'd2, 32'h4000_0500, 1'b0, 3'd2);
        tick();
        m_htrans[0] = 2'd0; m_htrans[1] = 2'd0;
        @(negedge clk);
        n_checks++;
        if (s_haddr !== 32'h4000_0500) begin
            n_fail++;
            $display("FAIL collide2_first: got haddr=%h want m1 40000500", s_haddr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (s_haddr !== 32'h4000_0400) begin
            n_fail++;
            $display("FAIL collide2_second: got haddr=%h want m0 40000400", s_haddr);
        end
        repeat (2) tick();
    endtask

    task automatic test_wait_states();
        do_reset();
        set_req(0, 2'd2, 32'h4000_0010, 1'b1, 3'd2);
        tick();
        m_htrans[0] = 2'd0;
        set_req(1, 2'd2, 32'h4000_0020, 1'b0, 3'd2);
        tick();
        m_htrans[1] = 2'd0;
        m_hwdata[0] = 32'h1234_5678;
        s_hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({s_htrans, s_haddr, m_hready[0], m_hready[1], s_hwdata} !== {2'd2, 32'h4000_0020, 1'b0, 1'b0, 32'h1234_5678}) begin
                n_fail++;
                $display("FAIL wait_cycle%0d: got htrans=%0d haddr=%h rdy=%b%b wdata=%h want 2 40000020 00 12345678",
                         k, s_htrans, s_haddr, m_hready[0], m_hready[1], s_hwdata);
            end
            tick();
        end
        s_hready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m_hready[0], s_haddr} !== {1'b1, 32'h4000_0020}) begin
            n_fail++;
            $display("FAIL wait_release: got m0rdy=%b haddr=%h want 1 40000020", m_hready[0], s_haddr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({m_hready[1], s_htrans} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL wait_m1_data: got m1rdy=%b htrans=%0d want 1 0", m_hready[1], s_htrans);
        end
        tick();
    endtask

    task automatic test_error();
        logic [31:0] rd = $urandom;
        set_req(1, 2'd2, 32'h4000_0030, 1'b0, 3'd2);
        tick();
        m_htrans[1] = 2'd0;
        tick();
        s_hready = 1'b0; s_hresp = 1'b1; s_hrdata = rd;
        @(negedge clk);
        n_checks++;
        if ({m_hready[1], m_hresp[1], m_hready[0], m_hresp[0]} !== 4'b0110) begin
            n_fail++;
            $display("FAIL err_cycle1: got m1=(%b,%b) m0=(%b,%b) want m1=(0,1) m0=(1,0)", m_hready[1], m_hresp[1], m_hready[0], m_hresp[0]);
        end
        n_checks++;
        if (m_hrdata[1] !== rd || m_hrdata[0] !== rd) begin
            n_fail++;
            $display("FAIL err_hrdata: got %h/%h want %h", m_hrdata[0], m_hrdata[1], rd);
        end
        tick();
        s_hready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m_hready[1], m_hresp[1], m_hready[0], m_hresp[0]} !== 4'b1110) begin
            n_fail++;
            $display("FAIL err_cycle2: got m1=(%b,%b) m0=(%b,%b) want m1=(1,1) m0=(1,0)", m_hready[1], m_hresp[1], m_hready[0], m_hresp[0]);
        end
        tick();
        s_hresp = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_req(1, 2'd2, 32'h4000_0040, 1'b0, 3'd2);
        tick();
        m_htrans[1] = 2'd0;
        set_req(0, 2'd2, 32'h4000_0050, 1'b1, 3'd2);
        tick();
        m_htrans[0] = 2'd0;
        s_hready = 1'b0;
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if ({s_htrans, s_haddr, m_hready[0], m_hready[1]} !== {2'd0, 32'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_now: got htrans=%0d haddr=%h rdy=%b%b want 0 0 11", s_htrans, s_haddr, m_hready[0], m_hready[1]);
        end
        @(negedge clk);
        s_hready = 1'b1;
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if ({s_htrans, m_hready[0], m_hready[1]} !== {2'd0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL midreset_after%0d: got htrans=%0d rdy=%b%b want 0 11", k, s_htrans, m_hready[0], m_hready[1]);
            end
        end
        tick();
    endtask

    task automatic test_type_mapping();
        set_req(0, 2'd1, 32'h4000_0060, 1'b0, 3'd2);
        tick();
        @(negedge clk);
        n_checks++;
        if ({s_htrans, m_hready[0]} !== {2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL busy_ignored: got htrans=%0d m0rdy=%b want 0 1", s_htrans, m_hready[0]);
        end
        set_req(0, 2'd3, 32'h4000_0008, 1'b0, 3'd2);
        tick();
        m_htrans[0] = 2'd0;
        @(negedge clk);
        n_checks++;
        if ({s_htrans, s_haddr} !== {2'd2, 32'h4000_0008}) begin
            n_fail++;
            $display("FAIL seq_as_nonseq: got htrans=%0d haddr=%h want 2 40000008", s_htrans, s_haddr);
        end
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [1:0]  prev_trans = 2'd0;
        logic [31:0] prev_addr = '0;
        bit          prev_wait = 0;
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            int          g;
            bit          any;
            logic [37:0] exp_ap;
            logic [31:0] exp_wd;
            logic [1:0]  exp_rdy, exp_resp;
            for (int m = 0; m < 2; m++) begin
                m_htrans[m] = 2'($urandom_range(0, 3));
                m_haddr[m] = $urandom;
                m_hwrite[m] = 1'($urandom_range(0, 1));
                m_hsize[m] = 3'($urandom_range(0, 2));
                m_hwdata[m] = $urandom;
            end
            s_hready = $urandom_range(0, 3) != 0;
            s_hresp = $urandom_range(0, 7) == 0;
            s_hrdata = $urandom;
            g = r_grant();
            any = r_pend[0] | r_pend[1];
            exp_ap = any ? {2'd2, r_addr[g], r_wr[g], r_sz[g]} : 38'd0;
            exp_wd = (r_owner >= 0) ? m_hwdata[r_owner] : 32'd0;
            for (int m = 0; m < 2; m++) begin
                exp_rdy[m] = r_ready(m);
                exp_resp[m] = (r_owner == m) && s_hresp;
            end
            @(negedge clk);
            n_checks++;
            if ({s_htrans, s_haddr, s_hwrite, s_hsize} !== exp_ap) begin
                n_fail++;
                $display("FAIL rand_addr_phase c=%0d: got %h want %h", c, {s_htrans, s_haddr, s_hwrite, s_hsize}, exp_ap);
            end
            n_checks++;
            if (s_hwdata !== exp_wd) begin
                n_fail++;
                $display("FAIL rand_hwdata c=%0d: got %h want %h", c, s_hwdata, exp_wd);
            end
            n_checks++;
            if ({m_hready[1], m_hready[0]} !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_hready c=%0d: got %b%b want %b", c, m_hready[1], m_hready[0], exp_rdy);
            end
            n_checks++;
            if ({m_hresp[1], m_hresp[0]} !== exp_resp) begin
                n_fail++;
                $display("FAIL rand_hresp c=%0d: got %b%b want %b", c, m_hresp[1], m_hresp[0], exp_resp);
            end
            n_checks++;
            if (m_hrdata[0] !== s_hrdata || m_hrdata[1] !== s_hrdata) begin
                n_fail++;
                $display("FAIL rand_hrdata c=%0d: got %h/%h want %h", c, m_hrdata[0], m_hrdata[1], s_hrdata);
            end
            if (s_hresp) begin
                n_checks++;
                if (m_hresp[0] && m_hresp[1]) begin
                    n_fail++;
                    $display("FAIL rand_two_owners c=%0d: got both hresp=1 want at most one data-phase owner", c);
                end
            end
            if (prev_wait) begin
                n_checks++;
                if ({s_htrans, s_haddr} !== {prev_trans, prev_addr}) begin
                    n_fail++;
                    $display("FAIL rand_stall_stable c=%0d: got %0d/%h want %0d/%h", c, s_htrans, s_haddr, prev_trans, prev_addr);
                end
            end
            prev_wait = (s_htrans == 2'd2) && !s_hready;
            prev_trans = s_htrans;
            prev_addr = s_haddr;
            model_edge();
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        nrst = 1'b0;
        test_reset();
        test_lone_write();
        test_collision();
        test_wait_states();
        test_error();
        test_reset_mid_op();
        test_type_mapping();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
